// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler
//   Arbitrates per-channel DAC code updates onto one shared DAC SPI serializer.
//   Each channel has a single pending slot. Slots are granted round-robin. The
//   granted code is framed as {CMD,code,4'b0} and handed to the serializer. A
//   minimum idle gap is enforced after each frame.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   req_valid   [NCH]     per-channel update request
//   req_data    [NCH*DW]  per-channel code, ch i at [DW*i +: DW]
//   req_ready   [NCH]     slot i empty (registered, = ~pend[i])
//   tx_start    one-cycle launch pulse to the serializer
//   tx_word     [16]      frame word, held from tx_start until the next grant
//   tx_cs_sel   [NCH]     one-hot target channel, cleared during the gap
//   tx_busy     serializer busy
//   sched_busy  FSM not idle, or any slot pending
//   frame_cnt   [16]      completed frames, modulo 2^16
//   err_to      sticky: serializer did not raise tx_busy within TO_CYC cycles
//   ldac_n      DAC load strobe, active low
//
// Build option
//   DAC_LDAC_EN  when defined, ldac_n pulses low for LDAC_W cycles on leaving
//                the gap with no slot pending, and new launches wait for the
//                pulse to finish. When undefined, ldac_n is tied high.
module dac_update_scheduler #(
   parameter int unsigned      NCH     = 2,
   parameter int unsigned      DW      = 8,
   parameter logic [4*NCH-1:0] CMD_TAB = 8'hF7,
   parameter int unsigned      GAP     = 2,
   parameter int unsigned      TO_CYC  = 8,
   parameter int unsigned      LDAC_W  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NCH-1:0]  req_valid,
   input  logic [NCH*DW-1:0] req_data,
   output logic [NCH-1:0]  req_ready,
   output logic            tx_start,
   output logic [15:0]     tx_word,
   output logic [NCH-1:0]  tx_cs_sel,
   input  logic            tx_busy,
   output logic            sched_busy,
   output logic [15:0]     frame_cnt,
   output logic            err_to,
   output logic            ldac_n
);

   localparam int unsigned PW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned CM0  = (TO_CYC > GAP) ? TO_CYC : GAP;
   localparam int unsigned CMAX = (CM0 > LDAC_W) ? CM0 : LDAC_W;
   localparam int unsigned CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t          state_q, state_d;
   logic [NCH-1:0]  pend_q, pend_d;
   logic [DW-1:0]   code_q [NCH];
   logic [PW-1:0]   rr_ptr;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NCH-1:0]  accept;

   logic            grant_found;
   logic [PW-1:0]   grant_idx;
   logic [PW-1:0]   srch;
   logic            grant;
   logic            to_hit;
   logic            done;
   logic            gap_end;
   logic            ldac_ok;

   assign accept     = req_valid & req_ready;
   assign sched_busy = (state_q != S_IDLE) || (|pend_q);
   assign gap_end    = (state_q == S_GAP) && (cnt_q == CW'(GAP - 1));

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      srch        = '0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         srch = PW'((32'(rr_ptr) + k) % NCH);
         if (!grant_found && pend_q[srch]) begin
            grant_found = 1'b1;
            grant_idx   = srch;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      to_hit  = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_found && ldac_ok) begin
               grant   = 1'b1;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: state_d = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q == CW'(TO_CYC - 1)) begin
               to_hit  = 1'b1;
               state_d = S_GAP;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               done    = 1'b1;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Counter runs only while dwelling in a timed state; any transition clears it.
      if ((state_d == state_q) && ((state_q == S_WAIT_ACK) || (state_q == S_GAP)))
         cnt_d = cnt_q + CW'(1);
      else
         cnt_d = '0;

      // Grant frees the slot at the same edge, so a new request can refill it next cycle.
      pend_d = pend_q;
      if (grant) pend_d[grant_idx] = 1'b0;
      pend_d = pend_d | accept;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pend_q    <= '0;
         req_ready <= '1;
         rr_ptr    <= PW'(NCH - 1);
         tx_start  <= 1'b0;
         tx_word   <= '0;
         tx_cs_sel <= '0;
         frame_cnt <= '0;
         err_to    <= 1'b0;
         for (int unsigned i = 0; i < NCH; i++) code_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         req_ready <= ~pend_d;
         tx_start  <= (state_q == S_LAUNCH);
         for (int unsigned i = 0; i < NCH; i++)
            if (accept[i]) code_q[i] <= req_data[DW*i +: DW];
         if (grant) begin
            rr_ptr    <= grant_idx;
            tx_word   <= 16'({CMD_TAB[4*grant_idx +: 4], code_q[grant_idx], 4'b0000});
            tx_cs_sel <= NCH'(1) << grant_idx;
         end else if ((state_d == S_GAP) && (state_q != S_GAP)) begin
            tx_cs_sel <= '0;
         end
         if (to_hit) err_to    <= 1'b1;
         if (done)   frame_cnt <= frame_cnt + 16'd1;
      end
   end

`ifdef DAC_LDAC_EN
   logic          ldac_q;
   logic [CW-1:0] lcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         ldac_q <= 1'b1;
         lcnt   <= '0;
      end else if (gap_end && (pend_q == '0)) begin
         ldac_q <= 1'b0;
         lcnt   <= '0;
      end else if (!ldac_q) begin
         if (lcnt == CW'(LDAC_W - 1)) ldac_q <= 1'b1;
         else                         lcnt   <= lcnt + CW'(1);
      end
   end

   assign ldac_ok = ldac_q;
   assign ldac_n  = ldac_q;
`else
   assign ldac_ok = 1'b1;
   assign ldac_n  = 1'b1;
`endif

endmodule

// File: tb/tb_dac_update_scheduler.sv
module tb_dac_update_scheduler;

   localparam int unsigned NCH    = 2;
   localparam int unsigned DW     = 8;
   localparam int unsigned GAP    = 2;
   localparam int unsigned TO_CYC = 8;
   localparam int unsigned LDAC_W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_ready;
   logic        tx_start;
   logic [15:0] tx_word;
   logic [1:0]  tx_cs_sel;
   logic        tx_busy = 1'b0;
   logic        sched_busy;
   logic [15:0] frame_cnt;
   logic        err_to;
   logic        ldac_n;

   always #5 clk = ~clk;

   dac_update_scheduler #(
      .NCH(NCH), .DW(DW), .CMD_TAB(8'hF7), .GAP(GAP), .TO_CYC(TO_CYC), .LDAC_W(LDAC_W)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_word(tx_word),
      .tx_cs_sel(tx_cs_sel), .tx_busy(tx_busy), .sched_busy(sched_busy),
      .frame_cnt(frame_cnt), .err_to(err_to), .ldac_n(ldac_n)
   );

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   int unsigned cyc = 0;
   logic [17:0] exp_q [$];   // {cs, word}

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [17:0] exp_frame(input int ch, input logic [7:0] code);
      logic [3:0] cmd;
      logic [1:0] cs;
      cmd = (ch == 0) ? 4'h7 : 4'hF;
      cs  = (ch == 0) ? 2'b01 : 2'b10;
      return {cs, cmd, code, 4'h0};
   endfunction

   // Serializer model: busy for 3 cycles after each tx_start when enabled.
   logic        ser_en = 1'b1;
   int unsigned bcnt = 0;
   int unsigned fall_cyc = 0;
   always @(negedge clk) begin
      if (ser_en && tx_start) begin
         tx_busy = 1'b1;
         bcnt    = 3;
      end else if (bcnt > 0) begin
         bcnt--;
         if (bcnt == 0) begin
            tx_busy  = 1'b0;
            fall_cyc = cyc;
         end
      end
   end

   // Monitor: every launch pops one expected frame.
   logic        prev_start = 1'b0;
   int unsigned start_gap = 0;
   always @(negedge clk) begin
      logic [17:0] e;
      if (tx_start) begin
         check("tx_start one cycle", prev_start, 0);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected tx_start: word %h cs %b, none expected (cycle %0d)",
                     tx_word, tx_cs_sel, cyc);
         end else begin
            e = exp_q.pop_front();
            check("tx_word", 32'(tx_word), 32'(e[15:0]));
            check("tx_cs_sel", 32'(tx_cs_sel), 32'(e[17:16]));
         end
         start_gap = cyc - fall_cyc;
      end
      prev_start = tx_start;
   end

   task automatic check_reset();
      check("rst tx_start", tx_start, 0);
      check("rst tx_word", tx_word, 0);
      check("rst tx_cs_sel", tx_cs_sel, 0);
      check("rst req_ready", req_ready, 2'b11);
      check("rst frame_cnt", frame_cnt, 0);
      check("rst err_to", err_to, 0);
      check("rst ldac_n", ldac_n, 1);
      check("rst sched_busy", sched_busy, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset();
   endtask

   task automatic wait_idle(input string name);
      int unsigned n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((sched_busy || !ldac_n) && n < 300);
      check({name, " idle reached"}, 32'(n < 300), 1);
   endtask

   task automatic wait_start(input string name);
      int unsigned n = 0;
      while (!tx_start && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, " tx_start seen"}, 32'(tx_start), 1);
   endtask

   task automatic send(input int ch, input logic [7:0] code);
      int unsigned n = 0;
      while (!req_ready[ch] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("send slot ready", req_ready[ch], 1);
      req_valid[ch]       = 1'b1;
      req_data[8*ch +: 8] = code;
      exp_q.push_back(exp_frame(ch, code));
      @(negedge clk);
      req_valid[ch] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      int unsigned acc0, acc1;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_reset();

      // 1: single request on ch0
      req_valid[0]  = 1'b1;
      req_data[7:0] = 8'hA5;
      exp_q.push_back({2'b01, 16'h7A50});
      @(negedge clk);
      req_valid[0] = 1'b0;
      n = 1;
      while (!tx_start && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("launch latency", n, 3);
      wait_idle("single");
      check("single frame_cnt", frame_cnt, 1);
      check("single req_ready", req_ready, 2'b11);
      check("single err_to", err_to, 0);

      // 2: both channels in the same cycle
      do_reset();
      req_valid = 2'b11;
      req_data  = {8'h22, 8'h11};
      exp_q.push_back({2'b01, 16'h7110});
      exp_q.push_back({2'b10, 16'hF220});
      @(negedge clk);
      req_valid = 2'b00;
      check("both accepted", req_ready, 2'b00);
      wait_idle("both");
      check("both frame_cnt", frame_cnt, 2);
      check("gap before 2nd launch", 32'(start_gap > GAP), 1);

      // 3: both channels re-requesting for 8 frames
      acc0 = 0;
      acc1 = 0;
      n    = 0;
      while ((acc0 < 4 || acc1 < 4) && n < 400) begin
         req_data[7:0]  = 8'h50 + 8'(acc0);
         req_data[15:8] = 8'h60 + 8'(acc1);
         req_valid[0]   = (acc0 < 4);
         req_valid[1]   = (acc1 < 4);
         if (req_valid[0] && req_ready[0]) begin
            exp_q.push_back(exp_frame(0, req_data[7:0]));
            acc0++;
         end
         if (req_valid[1] && req_ready[1]) begin
            exp_q.push_back(exp_frame(1, req_data[15:8]));
            acc1++;
         end
         @(negedge clk);
         n++;
      end
      req_valid = 2'b00;
      check("fair accepts done", 32'(n < 400), 1);
      wait_idle("fair");
      check("fair frame_cnt", frame_cnt, 10);
      check("fair err_to", err_to, 0);

      // 4: serializer never acknowledges
      ser_en = 1'b0;
      send(0, 8'h3C);
      wait_start("timeout");
      n = 0;
      while (!err_to && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("timeout cycles", n, TO_CYC);
      wait_idle("timeout");
      check("timeout frame_cnt", frame_cnt, 10);
      check("timeout err_to", err_to, 1);
      ser_en = 1'b1;
      send(1, 8'hC3);
      wait_idle("after timeout");
      check("after timeout frame_cnt", frame_cnt, 11);
      check("err_to sticky", err_to, 1);

      // 5: reset during WAIT_DONE with ch1 pending
      send(0, 8'h5A);
      wait_start("reset frame");
      req_valid[1]   = 1'b1;
      req_data[15:8] = 8'h99;
      @(negedge clk);
      req_valid[1] = 1'b0;
      check("mid-frame ch1 pending", req_ready, 2'b01);
      check("mid-frame busy", sched_busy, 1);
      do_reset();
      repeat (30) @(negedge clk);
      check("post reset frame_cnt", frame_cnt, 0);
      check("post reset sched_busy", sched_busy, 0);

`ifdef DAC_LDAC_EN
      // 6: load strobe width and launch hold-off
      begin
         int unsigned low;
         logic seen_high, early;
         send(0, 8'h0F);
         n = 0;
         while (ldac_n && n < 60) begin
            @(negedge clk);
            n++;
         end
         check("ldac pulse seen", ldac_n, 0);
         req_valid[1]   = 1'b1;
         req_data[15:8] = 8'hE1;
         exp_q.push_back(exp_frame(1, 8'hE1));
         low       = 1;
         seen_high = 1'b0;
         early     = 1'b0;
         n         = 0;
         while (!seen_high && n < 40) begin
            @(negedge clk);
            n++;
            req_valid[1] = 1'b0;
            if (ldac_n) seen_high = 1'b1;
            else        low++;
            if (tx_start && !seen_high) early = 1'b1;
         end
         check("ldac low width", low, LDAC_W);
         check("launch during ldac", early, 0);
         wait_idle("ldac");
         check("ldac frame_cnt", frame_cnt, 2);
      end
`endif

      check("scoreboard drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
